mem_line_bridge: RTL and testbench

//  Downstream neighbour of the data cache: accepts one 128-bit line read/write on the

---
 rtl/mem_bridge_pkg.sv | 9 +
 rtl/mem_line_bridge.sv | 84 ++++++++
 tb/tb_mem_line_bridge.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bridge_pkg.sv
// mem_bridge_pkg: shared state encoding and default sizing for the line-to-word memory bridge
package mem_bridge_pkg;
  localparam int BIT_W    = 32;
  localparam int ADDR_W   = 32;
  localparam int BEATS    = 4;
  localparam int OFFSET_W = $clog2(BEATS * BIT_W / 8);
  localparam int CNT_W    = $clog2(BEATS);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;
endpackage

// File: rtl/mem_line_bridge.sv
// mem_line_bridge: splits one cache line request into BEATS word beats on a stalling word memory
module mem_line_bridge #(
  parameter int BIT_W  = 32,
  parameter int ADDR_W = 32,
  parameter int BEATS  = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_cache_cen,
  input  logic                    i_cache_wen,
  input  logic [ADDR_W-1:0]       i_cache_addr,
  input  logic [BIT_W*BEATS-1:0]  i_cache_wdata,
  output logic [BIT_W*BEATS-1:0]  o_cache_rdata,
  output logic                    o_cache_stall,
  output logic                    o_mem_cen,
  output logic                    o_mem_wen,
  output logic [ADDR_W-1:0]       o_mem_addr,
  output logic [BIT_W-1:0]        o_mem_wdata,
  input  logic [BIT_W-1:0]        i_mem_rdata,
  input  logic                    i_mem_stall
);
  import mem_bridge_pkg::*;
  localparam int LINE_W = BIT_W * BEATS;
  localparam int OFF_W  = $clog2(LINE_W / 8);
  localparam int CW     = $clog2(BEATS);
  localparam int WB_W   = $clog2(BIT_W / 8);
  localparam logic [ADDR_W-1:0] OFF_MASK = {{(ADDR_W-OFF_W){1'b0}}, {OFF_W{1'b1}}};
  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                wen_q, wen_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [LINE_W-1:0]   wdata_q, wdata_d, rdata_q, rdata_d;
  logic                last;
  assign last = cnt_q == CW'(BEATS - 1);
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wen_q   <= 1'b0;
      base_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wen_q   <= wen_d;
      base_q  <= base_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wen_d   = wen_q;
    base_d  = base_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE:
        if (i_cache_cen) begin
          wen_d   = i_cache_wen;
          base_d  = i_cache_addr & ~OFF_MASK;
          wdata_d = i_cache_wdata;
          cnt_d   = '0;
          state_d = ISSUE;
        end
      ISSUE: state_d = i_mem_stall ? ISSUE : WAIT;
      WAIT:
        if (!i_mem_stall) begin
          if (!wen_q) rdata_d[cnt_q*BIT_W +: BIT_W] = i_mem_rdata;
          cnt_d   = last ? cnt_q : cnt_q + 1'b1;
          state_d = last ? DONE : ISSUE;
        end
      default: state_d = IDLE;
    endcase
  end
  // Request strobe feeds stall directly so the cache freezes in the same cycle it asks.
  assign o_cache_stall = (state_q == IDLE) ? i_cache_cen : (state_q != DONE);
  assign o_cache_rdata = rdata_q;
  assign o_mem_cen     = state_q == ISSUE;
  assign o_mem_wen     = o_mem_cen & wen_q;
  assign o_mem_addr    = o_mem_cen ? base_q + (ADDR_W'(cnt_q) << WB_W) : '0;
  assign o_mem_wdata   = o_mem_wen ? wdata_q[cnt_q*BIT_W +: BIT_W] : '0;
endmodule

// File: tb/tb_mem_line_bridge.sv
// tb_mem_line_bridge: randomized line traffic against a stalling word memory and a reference line model
module tb_mem_line_bridge;
  logic clk = 0, rst_n = 1;
  logic cache_cen = 0, cache_wen = 0;
  logic [31:0] cache_addr = 0;
  logic [127:0] cache_wdata = 0, rdata;
  logic cstall, mcen, mwen, mstall;
  logic [31:0] maddr, mwdata, mrdata = 0;
  int errors = 0, checks = 0, cyc_l = 3, scnt = 0;
  logic force_stall = 0, st0;
  logic [31:0] mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] log_a[$], log_d[$];
  logic log_w[$];
  logic [127:0] exp_rd = 0;

  mem_line_bridge dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_cache_cen(cache_cen), .i_cache_wen(cache_wen),
    .i_cache_addr(cache_addr), .i_cache_wdata(cache_wdata), .o_cache_rdata(rdata),
    .o_cache_stall(cstall), .o_mem_cen(mcen), .o_mem_wen(mwen), .o_mem_addr(maddr),
    .o_mem_wdata(mwdata), .i_mem_rdata(mrdata), .i_mem_stall(mstall)
  );

  always #5 clk = ~clk;
  assign mstall = (scnt != 0) || force_stall;

  // Word memory: goes busy for cyc_l cycles after each accepted beat, data ready when stall drops.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) scnt <= 0;
    else if (mcen && !mstall) begin
      scnt <= cyc_l;
      log_a.push_back(maddr); log_w.push_back(mwen); log_d.push_back(mwdata);
      if (mwen) mem[maddr] = mwdata;
      mrdata <= mem.exists(maddr) ? mem[maddr] : maddr ^ 32'hA5A5_0000;
    end else if (scnt != 0) scnt <= scnt - 1;

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : a ^ 32'hA5A5_0000;
  endfunction

  function automatic logic [127:0] ref_line(input logic [31:0] b);
    logic [127:0] l;
    for (int k = 0; k < 4; k++) l[k*32 +: 32] = ref_rd(b + 32'(k * 4));
    return l;
  endfunction

  task automatic issue(input logic w, input logic [31:0] a, input logic [127:0] wd, output int lat);
    log_a.delete(); log_w.delete(); log_d.delete();
    @(negedge clk);
    cache_cen = 1; cache_wen = w; cache_addr = a; cache_wdata = wd;
    #1 st0 = cstall;
    @(negedge clk);
    cache_cen = 0; cache_wen = 0;
    lat = -1;
    for (int k = 1; k < 300; k++) begin
      if (!cstall) begin lat = k; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    @(negedge clk); @(negedge clk);
    checks++;
    if ({cstall, mcen, mwen, maddr, mwdata} !== '0 || rdata !== '0)
      $display("FAIL reset_outputs: got stall=%b cen=%b wen=%b addr=%h wdata=%h rdata=%h, want all 0",
               cstall, mcen, mwen, maddr, mwdata, rdata);
    if (!(cstall === 1'b0)) errors++;
    else if ({mcen, mwen, maddr, mwdata} !== '0 || rdata !== '0) errors++;
    rst_n = 1;
  endtask

  task automatic test_read;
    int lat;
    logic [31:0] b = 32'h100;
    cyc_l = 3;
    issue(0, 32'h104, '0, lat);
    exp_rd = ref_line(b);
    checks++; if (st0 !== 1) begin errors++; $display("FAIL read_comb_stall: got %b want 1", st0); end
    checks++; if (lat != 21) begin errors++; $display("FAIL read_latency: got %0d want 21", lat); end
    checks++; if (log_a.size() != 4) begin errors++; $display("FAIL read_beats: got %0d want 4", log_a.size()); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (k >= log_a.size() || log_a[k] !== b + 32'(4*k) || log_w[k] !== 0) begin
        errors++; $display("FAIL read_beat%0d: got addr=%h want %h", k, k < log_a.size() ? log_a[k] : 32'hx, b + 32'(4*k));
      end
    end
    checks++;
    if (rdata !== 128'hA5A5010C_A5A50108_A5A50104_A5A50100 || rdata !== exp_rd) begin
      errors++; $display("FAIL read_data: got %h want %h", rdata, exp_rd);
    end
  endtask

  task automatic test_write;
    int lat;
    logic [127:0] wd = 128'h44444444_33333333_22222222_11111111;
    issue(1, 32'h200, wd, lat);
    for (int k = 0; k < 4; k++) ref_mem[32'h200 + 32'(4*k)] = wd[k*32 +: 32];
    checks++; if (lat != 21) begin errors++; $display("FAIL write_latency: got %0d want 21", lat); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (k >= log_a.size() || log_a[k] !== 32'h200 + 32'(4*k) || log_w[k] !== 1 || log_d[k] !== wd[k*32 +: 32]) begin
        errors++; $display("FAIL write_beat%0d: got addr=%h data=%h want %h/%h", k,
                           k < log_a.size() ? log_a[k] : 32'hx, k < log_d.size() ? log_d[k] : 32'hx,
                           32'h200 + 32'(4*k), wd[k*32 +: 32]);
      end
    end
    @(negedge clk);
    checks++; if (rdata !== exp_rd) begin errors++; $display("FAIL write_keeps_rdata: got %h want %h", rdata, exp_rd); end
  endtask

  task automatic test_stall_hold;
    int lat = -1;
    log_a.delete(); log_w.delete(); log_d.delete();
    @(negedge clk);
    force_stall = 1; cache_cen = 1; cache_wen = 0; cache_addr = 32'h104;
    @(negedge clk);
    cache_cen = 0;
    for (int i = 1; i <= 5; i++) begin
      checks++;
      if (mcen !== 1 || maddr !== 32'h100 || log_a.size() != 0) begin
        errors++; $display("FAIL stall_hold_c%0d: got cen=%b addr=%h want 1/00000100", i, mcen, maddr);
      end
      @(negedge clk);
    end
    force_stall = 0;
    for (int k = 6; k < 300; k++) begin
      if (!cstall) begin lat = k; break; end
      @(negedge clk);
    end
    checks++; if (lat != 26) begin errors++; $display("FAIL stall_latency: got %0d want 26", lat); end
    checks++; if (rdata !== ref_line(32'h100)) begin errors++; $display("FAIL stall_data: got %h want %h", rdata, ref_line(32'h100)); end
  endtask

  task automatic test_reset_mid;
    int lat, n = 0, seen;
    log_a.delete(); log_w.delete(); log_d.delete();
    @(negedge clk); cache_cen = 1; cache_wen = 0; cache_addr = 32'h180;
    @(negedge clk); cache_cen = 0;
    while (!(mcen === 1 && maddr === 32'h188) && n < 100) begin @(negedge clk); n++; end
    checks++; if (n >= 100) begin errors++; $display("FAIL reset_mid_reach: beat 2 never issued"); end
    rst_n = 0; exp_rd = '0;
    #1;
    checks++;
    if ({cstall, mcen, mwen, maddr, mwdata} !== '0 || rdata !== '0) begin
      errors++; $display("FAIL reset_mid_outputs: got stall=%b cen=%b addr=%h rdata=%h want all 0", cstall, mcen, maddr, rdata);
    end
    @(negedge clk); @(negedge clk); rst_n = 1;
    seen = log_a.size();
    repeat (10) @(negedge clk);
    checks++;
    if (log_a.size() != 2 || seen != 2 || mcen !== 0) begin
      errors++; $display("FAIL reset_mid_abort: got beats=%0d cen=%b want 2/0", log_a.size(), mcen);
    end
    issue(0, 32'h300, '0, lat);
    exp_rd = ref_line(32'h300);
    checks++;
    if (lat != 21 || log_a.size() == 0 || log_a[0] !== 32'h300 || rdata !== exp_rd) begin
      errors++; $display("FAIL reset_mid_recover: got lat=%0d rdata=%h want 21/%h", lat, rdata, exp_rd);
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    logic [127:0] wd = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 3; i++) begin
      logic w = (i == 1);
      issue(w, 32'h440, wd, lat);
      if (w) for (int k = 0; k < 4; k++) ref_mem[32'h440 + 32'(4*k)] = wd[k*32 +: 32];
      else exp_rd = ref_line(32'h440);
      checks++;
      if (st0 !== 1 || lat != 21 || rdata !== exp_rd) begin
        errors++; $display("FAIL b2b_%0d: got stall0=%b lat=%0d rdata=%h want 1/21/%h", i, st0, lat, rdata, exp_rd);
      end
    end
  endtask

  task automatic test_latency_sweep;
    int lat, ls[2] = '{1, 7};
    foreach (ls[j]) begin
      logic [31:0] b = {$urandom_range(0, 255), 4'h0} + 32'h8000;
      cyc_l = ls[j];
      issue(0, b | 32'h8, '0, lat);
      exp_rd = ref_line(b);
      checks++;
      if (lat != 1 + 4 * (ls[j] + 2) || rdata !== exp_rd) begin
        errors++; $display("FAIL sweep_L%0d: got lat=%0d rdata=%h want %0d/%h", ls[j], lat, rdata, 1 + 4 * (ls[j] + 2), exp_rd);
      end
    end
  endtask

  task automatic test_random;
    int lat;
    logic [31:0] bases[4] = '{32'h0, 32'h1230, 32'hFFFF_FFF0, 32'h7000_0040};
    for (int i = 0; i < 16; i++) begin
      logic w = 1'($urandom);
      logic [31:0] a = bases[$urandom_range(0, 3)] | 32'($urandom_range(0, 15));
      logic [31:0] b = a & ~32'hF;
      logic [127:0] wd = {$urandom, $urandom, $urandom, $urandom};
      logic ok = 1;
      cyc_l = $urandom_range(1, 7);
      issue(w, a, wd, lat);
      if (w) for (int k = 0; k < 4; k++) ref_mem[b + 32'(4*k)] = wd[k*32 +: 32];
      else exp_rd = ref_line(b);
      for (int k = 0; k < 4; k++)
        if (k >= log_a.size() || log_a[k] !== b + 32'(4*k) || log_w[k] !== w || log_d[k] !== (w ? wd[k*32 +: 32] : 32'h0)) ok = 0;
      checks++;
      if (!ok || log_a.size() != 4 || lat != 1 + 4 * (cyc_l + 2) || rdata !== exp_rd) begin
        errors++; $display("FAIL random_%0d: w=%b a=%h L=%0d got lat=%0d beats=%0d rdata=%h want rdata=%h",
                           i, w, a, cyc_l, lat, log_a.size(), rdata, exp_rd);
      end
    end
  endtask

  initial begin
    #1 rst_n = 0;
    test_reset;
    test_read;
    test_write;
    test_stall_hold;
    test_reset_mid;
    test_back_to_back;
    test_latency_sweep;
    test_random;
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors + 1, checks);
    $fatal(1, "timeout");
  end
endmodule
